// File: rtl/detector_jogada_pkg.sv
// detector_jogada package: FSM state codes
// and the one-hot check used to validate a press.
package detector_jogada_pkg;

  typedef enum logic [3:0] {
    OCIOSO           = 4'h0,
    ESTABILIZA       = 4'h1,
    VALIDA           = 4'h2,
    ESPERA_SOLTA     = 4'h3,
    SOLTA_ESTABILIZA = 4'h4
  } estado_t;

  function automatic logic eh_one_hot(
    input logic [3:0] v
  );
    return (v != 4'b0) &&
           ((v & (v - 4'd1)) == 4'b0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous
// inputs, synchronous active-high reset.
module sincronizador_2ff #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Key conditioning: sync, debounce, one-hot
// validation and release gating of player keys.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CONT_W          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves,
  input  logic       habilita,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       db_tem_jogada,
  output logic [3:0] db_estado
);

  localparam logic [CONT_W-1:0] LIMITE =
    CONT_W'(DEBOUNCE_CYCLES - 1);

  estado_t           estado;
  logic [CONT_W-1:0] cont;
  logic [3:0]        candidato;
  logic [3:0]        s_chaves;

  sincronizador_2ff #(
    .W(4)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (chaves),
    .q    (s_chaves)
  );

  assign db_tem_jogada = |s_chaves;
  assign db_estado     = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= OCIOSO;
      cont            <= '0;
      candidato       <= '0;
      jogada          <= '0;
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
    end else begin
      jogada_feita    <= 1'b0;
      jogada_invalida <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (habilita && s_chaves != 4'b0) begin
            candidato <= s_chaves;
            cont      <= '0;
            estado    <= ESTABILIZA;
          end
        end
        ESTABILIZA: begin
          if (s_chaves != candidato) begin
            cont   <= '0;
            estado <= OCIOSO;
          end else if (cont == LIMITE) begin
            cont   <= '0;
            estado <= VALIDA;
            // strobe is registered so it lines up with VALIDA
            if (eh_one_hot(candidato)) begin
              jogada       <= candidato;
              jogada_feita <= 1'b1;
            end else begin
              jogada_invalida <= 1'b1;
            end
          end else begin
            cont <= cont + 1'b1;
          end
        end
        VALIDA: begin
          cont   <= '0;
          estado <= ESPERA_SOLTA;
        end
        ESPERA_SOLTA: begin
          if (s_chaves == 4'b0) begin
            cont   <= '0;
            estado <= SOLTA_ESTABILIZA;
          end
        end
        SOLTA_ESTABILIZA: begin
          if (s_chaves != 4'b0) begin
            cont   <= '0;
            estado <= ESPERA_SOLTA;
          end else if (cont == LIMITE) begin
            cont   <= '0;
            estado <= OCIOSO;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        default: begin
          cont   <= '0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada: reference model
// compared every cycle plus directed literal checks.
module tb_detector_jogada;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] chaves;
  logic       habilita;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic       db_tem_jogada;
  logic [3:0] db_estado;

  detector_jogada #(
    .DEBOUNCE_CYCLES(D),
    .CONT_W         (3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .chaves         (chaves),
    .habilita       (habilita),
    .jogada         (jogada),
    .jogada_feita   (jogada_feita),
    .jogada_invalida(jogada_invalida),
    .db_tem_jogada  (db_tem_jogada),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_feita = 0;
  int n_inv = 0;
  int feita_cyc = -1;
  bit chk_en = 0;

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1 acquiring,
  // 2 report, 3 waiting release, 4 release settling.
  int         md = 0;
  int         run = 0;
  logic [3:0] cand = 0;
  logic [3:0] m_jog = 0;
  logic       m_feita = 0;
  logic       m_inv = 0;
  logic [3:0] m_s1 = 0;
  logic [3:0] m_s2 = 0;
  logic [3:0] s;

  always @(posedge clock) begin
    cyc++;
    s = m_s2;
    m_feita = 0;
    m_inv = 0;
    if (reset) begin
      md = 0; run = 0; cand = 0; m_jog = 0;
      m_s1 = 0; m_s2 = 0;
    end else begin
      case (md)
        0: if (habilita && s != 0) begin
             cand = s; run = 0; md = 1;
           end
        1: if (s != cand) md = 0;
           else begin
             run++;
             if (run == D) begin
               md = 2;
               if ($countones(cand) == 1) begin
                 m_jog = cand; m_feita = 1;
               end else m_inv = 1;
             end
           end
        2: md = 3;
        3: if (s == 0) begin md = 4; run = 0; end
        4: if (s != 0) md = 3;
           else begin
             run++;
             if (run == D) md = 0;
           end
        default: md = 0;
      endcase
      m_s2 = m_s1;
      m_s1 = chaves;
    end
  end

  always @(negedge clock) begin
    if (jogada_feita === 1'b1) begin
      n_feita++; feita_cyc = cyc;
    end
    if (jogada_invalida === 1'b1) n_inv++;
    if (chk_en) begin
      chk("jogada", jogada, m_jog);
      chk("jogada_feita", {3'b0, jogada_feita}, {3'b0, m_feita});
      chk("jogada_invalida", {3'b0, jogada_invalida}, {3'b0, m_inv});
      chk("db_tem_jogada", {3'b0, db_tem_jogada}, {3'b0, |m_s2});
      chk("db_estado", db_estado, 4'(md));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  int e0, f0, i0;

  initial begin
    reset = 1; chaves = 0; habilita = 0;
    step(2);
    chk("rst_jogada", jogada, 4'b0000);
    chk("rst_estado", db_estado, 4'h0);
    chk("rst_feita", {3'b0, jogada_feita}, 4'h0);
    chk("rst_inv", {3'b0, jogada_invalida}, 4'h0);
    chk("rst_tem", {3'b0, db_tem_jogada}, 4'h0);
    reset = 0;
    chk_en = 1;
    step(2);

    // reset in the middle of debounce
    habilita = 1; chaves = 4'b0001;
    step(4);
    chk("mid_estab", db_estado, 4'h1);
    reset = 1; chaves = 0;
    step(1);
    chk("mid_rst_estado", db_estado, 4'h0);
    chk("mid_rst_jogada", jogada, 4'b0000);
    reset = 0;
    step(12);
    chk("mid_rst_no_strobe", 4'(n_feita + n_inv), 4'd0);

    // clean press
    e0 = cyc; chaves = 4'b0100;
    step(3);
    chk("clean_st1", db_estado, 4'h1);
    step(4);
    chk("clean_st2", db_estado, 4'h2);
    chk("clean_feita", {3'b0, jogada_feita}, 4'h1);
    chk("clean_jogada", jogada, 4'b0100);
    step(1);
    chk("clean_st3", db_estado, 4'h3);
    chk("clean_feita_off", {3'b0, jogada_feita}, 4'h0);
    chk("clean_edge", 4'(feita_cyc - e0), 4'd7);
    chk("clean_count", 4'(n_feita), 4'd1);
    chaves = 0;
    step(10);

    // multi-key press
    f0 = n_feita; i0 = n_inv;
    chaves = 4'b0011;
    step(12);
    chk("multi_inv", 4'(n_inv - i0), 4'd1);
    chk("multi_feita", 4'(n_feita - f0), 4'd0);
    chk("multi_jogada", jogada, 4'b0100);
    chk("multi_wait", db_estado, 4'h3);
    chaves = 0;
    step(10);

    // bouncing key
    f0 = n_feita;
    for (int i = 0; i < 5; i++) begin
      chaves = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      step(2);
    end
    chaves = 4'b0010;
    step(12);
    chk("bounce_count", 4'(n_feita - f0), 4'd1);
    chk("bounce_jogada", jogada, 4'b0010);
    chaves = 0;
    step(10);

    // release gating
    f0 = n_feita;
    chaves = 4'b1000;
    step(10);
    chaves = 0;
    step(2);
    chaves = 4'b1000;
    step(10);
    chk("gate_one", 4'(n_feita - f0), 4'd1);
    chk("gate_jogada", jogada, 4'b1000);
    chaves = 0;
    step(10);
    chk("gate_idle", db_estado, 4'h0);
    chaves = 4'b0100;
    step(10);
    chk("gate_next", 4'(n_feita - f0), 4'd2);
    chaves = 0;
    step(10);

    // habilita low, then raised with key held
    f0 = n_feita;
    habilita = 0; chaves = 4'b0001;
    step(10);
    chk("hab_idle", db_estado, 4'h0);
    chk("hab_none", 4'(n_feita - f0), 4'd0);
    habilita = 1;
    step(10);
    chk("hab_count", 4'(n_feita - f0), 4'd1);
    chk("hab_jogada", jogada, 4'b0001);
    chaves = 0;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
